// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B, LSB first, one borrow flop.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output V.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             V
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_sh_reg, b_sh_reg, d_reg;
   logic [CW-1:0]    cnt_reg;
   logic             borrow_reg, bout_reg;
   logic             accept, last_bit, a_bit, b_bit, d_bit, borrow_next;

   assign a_bit       = a_sh_reg[0];
   assign b_bit       = b_sh_reg[0];
   assign d_bit       = a_bit ^ b_bit ^ borrow_reg;
   assign borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_reg);
   assign last_bit    = (cnt_reg == CW'(WIDTH - 1));

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_bit) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // D/Bout only move while bits are in flight; they hold across IDLE and DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_reg   <= '0;
         b_sh_reg   <= '0;
         d_reg      <= '0;
         cnt_reg    <= '0;
         borrow_reg <= 1'b0;
         bout_reg   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         V          <= 1'b0;
`endif
      end else if (accept) begin
         a_sh_reg   <= A;
         b_sh_reg   <= B;
         cnt_reg    <= '0;
         borrow_reg <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         V          <= 1'b0;
`endif
      end else if (state_reg == RUN) begin
         a_sh_reg   <= a_sh_reg >> 1;
         b_sh_reg   <= b_sh_reg >> 1;
         d_reg      <= {d_bit, d_reg[WIDTH-1:1]};
         cnt_reg    <= cnt_reg + 1'b1;
         borrow_reg <= borrow_next;
         if (last_bit) begin
            bout_reg <= borrow_next;
`ifdef SERIAL_SUB_OVF_EN
            // At the MSB, operands of differing sign with a result whose
            // sign differs from A means the signed difference overflowed.
            V        <= (a_bit != b_bit) && (d_bit != a_bit);
`endif
         end
      end
   end

   assign busy = (state_reg == RUN);
   assign done = (state_reg == DONE);
   assign D    = d_reg;
   assign Bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed checks for serial_subtractor (WIDTH=8): vector table plus
// reset-abort, ignored-start and restart-from-DONE sequences.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a_in, b_in;
   logic         busy, done, bout;
   logic [W-1:0] d;
`ifdef SERIAL_SUB_OVF_EN
   logic         v;
`endif

   int check_cnt = 0;
   int pass_cnt  = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (a_in),
      .B     (b_in),
      .busy  (busy),
      .done  (done),
      .D     (d),
      .Bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .V     (v)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] d;
      logic         bout;
      logic         v;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Issue one operation and wait (bounded) for done; returns edges counted.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int cycles);
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_accept", busy, 1'b1);
      chk("done_after_accept", done, 1'b0);
      cycles = 0;
      while (!done && cycles < 20) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   vec_t vecs[10];
   int   cyc;
   logic [W:0] ref_full;

   initial begin
      vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
      vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
      vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
      vecs[6] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
      vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
      vecs[8] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};
      vecs[9] = '{8'hC8, 8'h64, 8'h64, 1'b0, 1'b1};

      rst_n = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      #2;
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_d", d, 8'h00);
      chk("reset_bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
      chk("reset_v", v, 1'b0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_busy", busy, 1'b0);

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].a, vecs[i].b, cyc);
         $display("op %02h - %02h -> D=%02h Bout=%0b after %0d cycles", vecs[i].a, vecs[i].b, d, bout, cyc);
         chk("latency", cyc, W);
         chk("vec_d", d, vecs[i].d);
         chk("vec_bout", bout, vecs[i].bout);
         chk("vec_busy", busy, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
         chk("vec_v", v, vecs[i].v);
`endif
      end

      // Reset partway through an operation aborts it immediately.
      @(negedge clk);
      a_in = 8'h10; b_in = 8'h01; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_d", d, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h09, 8'h04, cyc);
      $display("op 09 - 04 after reset -> D=%02h Bout=%0b", d, bout);
      chk("post_abort_latency", cyc, W);
      chk("post_abort_d", d, 8'h05);

      // start asserted while busy must be ignored.
      @(negedge clk);
      a_in = 8'h20; b_in = 8'h01; start = 1'b1;
      @(posedge clk); #1;
      a_in = 8'hAA; b_in = 8'h00;
      repeat (7) @(posedge clk);
      #1;
      chk("busy_mid_run", busy, 1'b1);
      start = 1'b0;
      @(posedge clk); #1;
      $display("op 20 - 01 with stray starts -> D=%02h done=%0b", d, done);
      chk("ignore_done", done, 1'b1);
      chk("ignore_d", d, 8'h1F);
      chk("ignore_bout", bout, 1'b0);

      // Restart directly from DONE: done drops on the accept edge.
      @(negedge clk);
      a_in = 8'h01; b_in = 8'h02; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("restart_done_low", done, 1'b0);
      chk("restart_busy", busy, 1'b1);
      chk("restart_d_held", d, 8'h1F);
      repeat (7) @(posedge clk);
      #1;
      chk("restart_not_early", done, 1'b0);
      @(posedge clk); #1;
      $display("op 01 - 02 from DONE -> D=%02h Bout=%0b", d, bout);
      chk("restart_done", done, 1'b1);
      chk("restart_d", d, 8'hFF);
      chk("restart_bout", bout, 1'b1);

      // A handful of pseudo-random pairs against a plain reference subtraction.
      for (int i = 0; i < 12; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         ref_full = {1'b0, ra} - {1'b0, rb};
         run_op(ra, rb, cyc);
         $display("rnd %02h - %02h -> D=%02h Bout=%0b", ra, rb, d, bout);
         chk("rnd_d", d, ref_full[W-1:0]);
         chk("rnd_bout", bout, ref_full[W]);
`ifdef SERIAL_SUB_OVF_EN
         chk("rnd_v", v, (ra[W-1] != rb[W-1]) && (ref_full[W-1] != ra[W-1]));
`endif
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
